alu_arbiter: RTL

- Shares one `alu` instance (32-bit operands, 3-bit `ctl`) between two requesters, e.g. the execute stage and the address/PC-increment path.
- Per-requester valid/ready request channel and valid/ready response channel.
- Round-robin arbitration with one registered result slot tagged by owner.
- Per-requester wrapping issue counters for performance monitoring.

---
 rtl/alu_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// alu_arbiter
//   Shares one combinational ALU between two requesters. Each requester has a
//   valid/ready request channel and a valid/ready response channel. Contested
//   cycles are resolved round-robin. One registered result slot, tagged with
//   its owner, holds the result until the owner consumes it. Per-requester
//   wrapping counters record accepted requests.
//
// Ports
//   clk, reset_n                   clock, asynchronous active-low reset
//   req_valid_i / req_ready_i      request handshake, requester i (0/1)
//   req_a_i, req_b_i, req_ctl_i    operands and ALU op code, requester i
//   resp_valid_i / resp_ready_i    response handshake, requester i
//   resp_result                    shared slot result (qualified by resp_valid_*)
//   issue_cnt_i                    accepted-request count, requester i
// -----------------------------------------------------------------------------

// Purely combinational ALU.
//   000 ADD, 010 SLT (unsigned), 100 XOR, 110 OR, 111 AND, others -> 0.
module alu (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  ctl,
  output logic [31:0] result
);
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    result = '0;
    unique case (ctl)
      3'b000:  result = a + b;
      3'b010:  result = {31'b0, (a < b)};
      3'b100:  result = a ^ b;
      3'b110:  result = a | b;
      3'b111:  result = a & b;
      default: result = '0;
    endcase
  end
endmodule

module alu_arbiter #(
  parameter bit RR_INIT = 1'b0,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid_0,
  input  logic             req_valid_1,
  output logic             req_ready_0,
  output logic             req_ready_1,
  input  logic [31:0]      req_a_0,
  input  logic [31:0]      req_a_1,
  input  logic [31:0]      req_b_0,
  input  logic [31:0]      req_b_1,
  input  logic [2:0]       req_ctl_0,
  input  logic [2:0]       req_ctl_1,
  output logic             resp_valid_0,
  output logic             resp_valid_1,
  input  logic             resp_ready_0,
  input  logic             resp_ready_1,
  output logic [31:0]      resp_result,
  output logic [CNT_W-1:0] issue_cnt_0,
  output logic [CNT_W-1:0] issue_cnt_1
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

  slot_state_t      state_q, state_d;
  logic [31:0]      slot_result_q;
  logic             slot_owner_q;
  logic             last_grant_q;
  logic [CNT_W-1:0] cnt_0_q, cnt_1_q;

  logic        grant_0, grant_1;
  logic        drain, can_accept, accept, accept_id;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [2:0]  alu_ctl;

  // Round-robin grant: a lone requester always wins; when both ask, the one
  // that did not win the last accepted request wins.
  always_comb begin
    grant_0 = 1'b0;
    grant_1 = 1'b0;
    if (req_valid_0 && req_valid_1) begin
      grant_0 = last_grant_q;
      grant_1 = ~last_grant_q;
    end else begin
      grant_0 = req_valid_0;
      grant_1 = req_valid_1;
    end
  end

  // The slot can take a new result when empty, or when its owner consumes
  // the current one this same cycle (back-to-back throughput).
  assign drain      = (state_q == FULL) &&
                      (slot_owner_q ? resp_ready_1 : resp_ready_0);
  assign can_accept = (state_q == EMPTY) || drain;

  // Readies are gated by reset_n so nothing is accepted while reset is held.
  assign req_ready_0 = reset_n & grant_0 & can_accept;
  assign req_ready_1 = reset_n & grant_1 & can_accept;
  assign accept      = req_ready_0 | req_ready_1;
  assign accept_id   = grant_1;

  // Operands come from the granted requester.
  assign alu_a   = grant_1 ? req_a_1   : req_a_0;
  assign alu_b   = grant_1 ? req_b_1   : req_b_0;
  assign alu_ctl = grant_1 ? req_ctl_1 : req_ctl_0;

  alu u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .ctl    (alu_ctl),
    .result (alu_result)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL:    if (drain && !accept) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // NOTE: the slot data register is reset too, because resp_result is a
  // direct view of it and must read 0 out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= EMPTY;
      slot_result_q <= '0;
      slot_owner_q  <= 1'b0;
      last_grant_q  <= ~RR_INIT;
      cnt_0_q       <= '0;
      cnt_1_q       <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register
      // samples the pre-edge values regardless of statement order.
      state_q <= state_d;
      if (accept) begin
        slot_result_q <= alu_result;
        slot_owner_q  <= accept_id;
        last_grant_q  <= accept_id;
        if (accept_id) cnt_1_q <= cnt_1_q + CNT_W'(1);
        else           cnt_0_q <= cnt_0_q + CNT_W'(1);
      end
    end
  end

  assign resp_valid_0 = (state_q == FULL) && !slot_owner_q;
  assign resp_valid_1 = (state_q == FULL) &&  slot_owner_q;
  assign resp_result  = slot_result_q;
  assign issue_cnt_0  = cnt_0_q;
  assign issue_cnt_1  = cnt_1_q;

endmodule
